cola_dispenser: RTL and testbench

Dispense controller on the output side of the cola vending FSM. It takes that FSM's single-cycle `po_cola` purchase pulse, queues pending purchases, and drives the can-release motor for a fixed time. It then confirms each release through a drop sensor and reports completion, timeout errors and queue overflow to the rest of the vending design.

---
 rtl/cola_dispenser.sv | 156 +++++++++++++++
 tb/tb_cola_dispenser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cola_dispenser.sv
// Dispense controller: queues purchase pulses from the vending FSM, runs the
// can-release motor for a fixed time per can, confirms each release through a
// synchronized drop sensor and reports completion, timeout and overflow.
//
// Handshake note: po_cola is a one-cycle request with no back-pressure. It is
// either accepted into the pending count or rejected, and a rejection is
// signalled by a one-cycle overflow pulse. dispensed is a one-cycle completion
// pulse with no acknowledge.
module cola_dispenser #(
    parameter int MOTOR_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int PEND_MAX       = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       po_cola,
    input  logic       drop_sensor,
    input  logic       clr_err,
    output logic       motor_en,
    output logic       dispensed,
    output logic [2:0] pending,
    output logic       busy,
    output logic       err,
    output logic       overflow
);

    localparam int CNT_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] MOTOR_LOAD   = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    PEND_LIM     = 3'(PEND_MAX);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RUN  = 4'b0010,
        ST_WAIT = 4'b0100,
        ST_ERR  = 4'b1000
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          drop_seen, drop_seen_nxt;
    logic          dispense_nxt;
    logic          deq;
    logic          inc_ok;
    logic [2:0]    pending_nxt;
    logic          sync1, sync2, sync3;
    logic          drop_evt;

    // Rising edge of the synchronized sensor level.
    assign drop_evt = sync2 & ~sync3;

    // busy and err decode straight from the state register.
    assign busy = (state == ST_RUN) || (state == ST_WAIT);
    assign err  = (state == ST_ERR);

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= drop_sensor;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Next-state, counter and dispense-pulse decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        drop_seen_nxt = drop_seen;
        dispense_nxt  = 1'b0;
        deq           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending != 3'd0) begin
                    state_nxt     = ST_RUN;
                    cnt_nxt       = MOTOR_LOAD;
                    drop_seen_nxt = 1'b0;
                    deq           = 1'b1;
                end
            end
            ST_RUN: begin
                if (drop_evt) begin
                    drop_seen_nxt = 1'b1;
                end
                if (cnt == '0) begin
                    if (drop_seen || drop_evt) begin
                        state_nxt    = ST_IDLE;
                        dispense_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = TIMEOUT_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_WAIT: begin
                if (drop_evt) begin
                    state_nxt    = ST_IDLE;
                    dispense_nxt = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = ST_ERR;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending queue count: a full queue only accepts when a dequeue frees a slot.
    always_comb begin
        inc_ok      = po_cola && ((pending != PEND_LIM) || deq);
        pending_nxt = pending;
        if (inc_ok && !deq) begin
            pending_nxt = pending + 3'd1;
        end else if (!inc_ok && deq) begin
            pending_nxt = pending - 3'd1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            drop_seen <= 1'b0;
            pending   <= 3'd0;
            motor_en  <= 1'b0;
            dispensed <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            drop_seen <= drop_seen_nxt;
            pending   <= pending_nxt;
            motor_en  <= (state_nxt == ST_RUN);
            dispensed <= dispense_nxt;
            overflow  <= po_cola && !inc_ok;
        end
    end

endmodule

// File: tb/tb_cola_dispenser.sv
// Directed and random bench for cola_dispenser with MOTOR_CYCLES=4,
// TIMEOUT_CYCLES=10, PEND_MAX=3.
module tb_cola_dispenser;

    logic       clk;
    logic       rst_n;
    logic       po_cola;
    logic       drop_sensor;
    logic       clr_err;
    logic       motor_en;
    logic       dispensed;
    logic [2:0] pending;
    logic       busy;
    logic       err;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    cola_dispenser #(
        .MOTOR_CYCLES  (4),
        .TIMEOUT_CYCLES(10),
        .PEND_MAX      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .po_cola    (po_cola),
        .drop_sensor(drop_sensor),
        .clr_err    (clr_err),
        .motor_en   (motor_en),
        .dispensed  (dispensed),
        .pending    (pending),
        .busy       (busy),
        .err        (err),
        .overflow   (overflow)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_motor(input string tag, input int bound);
        for (int i = 0; i < bound && !motor_en; i++) tick();
        chk(tag, int'(motor_en), 1);
    endtask

    task automatic wait_dispensed(input string tag, input int bound);
        for (int i = 0; i < bound && !dispensed; i++) tick();
        chk(tag, int'(dispensed), 1);
    endtask

    task automatic wait_err(input string tag, input int bound);
        for (int i = 0; i < bound && !err; i++) tick();
        chk(tag, int'(err), 1);
    endtask

    // One can: wait for the motor, check queue depth, pulse the sensor, expect completion.
    task automatic do_can(input string tag, input int exp_pend);
        wait_motor({tag, "_motor"}, 30);
        chk({tag, "_pend"}, int'(pending), exp_pend);
        drop_sensor = 1'b1;
        repeat (3) tick();
        drop_sensor = 1'b0;
        wait_dispensed({tag, "_disp"}, 30);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    task automatic pulse_po();
        po_cola = 1'b1;
        tick();
        po_cola = 1'b0;
    endtask

    int ovf_cnt;
    int n_req, n_ovf, n_disp, n_err, bad_pend, bad_ovf, bad_motor;
    int hold;
    logic [2:0] prev_pend;
    logic prev_err;

    initial begin
        rst_n       = 1'b0;
        po_cola     = 1'b0;
        drop_sensor = 1'b0;
        clr_err     = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_motor", int'(motor_en), 0);
        chk("rst_disp", int'(dispensed), 0);
        chk("rst_pend", int'(pending), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single purchase: motor 4 cycles, sensor seen during RUN
        pulse_po();                                    // edge k
        chk("t1_pend_k", int'(pending), 1);
        chk("t1_motor_k", int'(motor_en), 0);
        tick();                                        // k+1
        chk("t1_pend_run", int'(pending), 0);
        chk("t1_motor_k1", int'(motor_en), 1);
        chk("t1_busy", int'(busy), 1);
        drop_sensor = 1'b1;
        tick(); chk("t1_motor_k2", int'(motor_en), 1);
        tick(); chk("t1_motor_k3", int'(motor_en), 1);
        tick(); chk("t1_motor_k4", int'(motor_en), 1);
        drop_sensor = 1'b0;
        chk("t1_disp_early", int'(dispensed), 0);
        tick();                                        // k+5
        chk("t1_motor_off", int'(motor_en), 0);
        chk("t1_disp", int'(dispensed), 1);
        chk("t1_busy_off", int'(busy), 0);
        chk("t1_err", int'(err), 0);
        tick();
        chk("t1_disp_once", int'(dispensed), 0);
        repeat (4) tick();

        // Late drop: sensor 5 cycles after motor stops
        pulse_po();                                    // k
        repeat (5) tick();                             // k+5, WAIT
        chk("t2_motor_off", int'(motor_en), 0);
        chk("t2_busy_wait", int'(busy), 1);
        repeat (4) tick();                             // k+9
        drop_sensor = 1'b1;
        tick(); tick();                                // k+11
        drop_sensor = 1'b0;
        chk("t2_disp_early", int'(dispensed), 0);
        tick();                                        // k+12
        chk("t2_disp", int'(dispensed), 1);
        chk("t2_busy", int'(busy), 0);
        chk("t2_err", int'(err), 0);
        tick();
        chk("t2_disp_once", int'(dispensed), 0);
        repeat (4) tick();

        // Timeout with a second request queued
        pulse_po();                                    // k
        tick();                                        // k+1
        pulse_po();                                    // k+2
        repeat (3) tick();                             // k+5
        chk("t3_motor_off", int'(motor_en), 0);
        chk("t3_busy_wait", int'(busy), 1);
        repeat (9) tick();                             // k+14
        chk("t3_err_early", int'(err), 0);
        tick();                                        // k+15
        chk("t3_err", int'(err), 1);
        chk("t3_busy_err", int'(busy), 0);
        chk("t3_pend", int'(pending), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_err_clr", int'(err), 0);
        chk("t3_motor_idle", int'(motor_en), 0);
        tick();
        chk("t3_motor_next", int'(motor_en), 1);
        do_can("t3_can", 0);
        repeat (4) tick();

        // Overflow in ERR with PEND_MAX=3
        pulse_po();
        wait_err("t4_err", 40);
        ovf_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_po();
            ovf_cnt += int'(overflow);
            tick();
            ovf_cnt += int'(overflow);
        end
        chk("t4_pend_sat", int'(pending), 3);
        chk("t4_ovf_cnt", ovf_cnt, 2);
        chk("t4_err_hold", int'(err), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        do_can("t4_can1", 2);
        do_can("t4_can2", 1);
        do_can("t4_can3", 0);
        repeat (4) tick();

        // Request on the same edge as IDLE->RUN with pending=2
        pulse_po();
        wait_err("t5_err", 40);
        pulse_po();
        tick();
        pulse_po();
        chk("t5_pend2", int'(pending), 2);
        clr_err = 1'b1;
        tick();                                        // ERR -> IDLE
        clr_err = 1'b0;
        pulse_po();                                    // IDLE -> RUN with request
        chk("t5_pend_same", int'(pending), 2);
        chk("t5_motor", int'(motor_en), 1);
        chk("t5_ovf", int'(overflow), 0);
        do_can("t5_can1", 2);
        do_can("t5_can2", 1);
        do_can("t5_can3", 0);
        repeat (4) tick();

        // Asynchronous reset mid-RUN
        po_cola = 1'b1;
        tick();
        tick();
        po_cola = 1'b0;
        tick();
        chk("t6_motor_pre", int'(motor_en), 1);
        chk("t6_pend_pre", int'(pending), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_motor_rst", int'(motor_en), 0);
        chk("t6_pend_rst", int'(pending), 0);
        chk("t6_busy_rst", int'(busy), 0);
        chk("t6_disp_rst", int'(dispensed), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("t6_busy_after", int'(busy), 0);
        pulse_po();
        do_can("t6_can", 0);
        repeat (4) tick();

        // Random traffic with conservation check
        n_req = 0; n_ovf = 0; n_disp = 0; n_err = 0;
        bad_pend = 0; bad_ovf = 0; bad_motor = 0;
        hold = 0;
        prev_pend = pending;
        prev_err = err;
        for (int c = 0; c < 10000; c++) begin
            po_cola = ($urandom_range(0, 9) == 0);
            if (po_cola) n_req++;
            if (hold == 0 && $urandom_range(0, 19) == 0) hold = $urandom_range(1, 4);
            drop_sensor = (hold != 0);
            if (hold != 0) hold--;
            clr_err = err && ($urandom_range(0, 3) == 0);
            tick();
            if (overflow) begin
                n_ovf++;
                if (prev_pend != 3'd3) bad_ovf++;
            end
            if (dispensed) n_disp++;
            if (err && !prev_err) n_err++;
            if (pending > 3'd3) bad_pend++;
            if (motor_en && err) bad_motor++;
            prev_pend = pending;
            prev_err = err;
        end
        po_cola = 1'b0;
        drop_sensor = 1'b0;
        clr_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (overflow) n_ovf++;
            if (dispensed) n_disp++;
            if (err && !prev_err) n_err++;
            prev_err = err;
        end
        chk("rnd_conserve", n_disp + n_err + int'(pending) + int'(busy), n_req - n_ovf);
        chk("rnd_pend_range", bad_pend, 0);
        chk("rnd_ovf_when_full", bad_ovf, 0);
        chk("rnd_motor_in_err", bad_motor, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
